uart_rx_fifo: RTL

//  Receive buffer between uart_rx and the ULM I/O interface. Captures every byte

---
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between uart_rx and the CPU getc path: show-ahead read, sticky overflow.
// Define UART_RX_FIFO_EOP_EN to store a per-entry end-of-packet tag alongside each byte.
module uart_rx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx_ready,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_eop,
   input  logic                       pop,
   output logic                       rd_valid,
   output logic [7:0]                 rd_data,
   output logic                       rd_eop,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_eff;
   logic          wr_en;
   logic          drop;

   assign rd_valid = (count != '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop_eff  = pop && rd_valid;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign wr_en    = rx_ready && (!full || pop_eff);
   assign drop     = rx_ready && full && !pop_eff;
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop_eff})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_EOP_EN
   logic [DEPTH-1:0] tag;
   logic [AW-1:0]    last_ptr;
   logic             eop_set;

   assign last_ptr = wr_ptr - AW'(1);
   // The most recent byte is the head when count==1; popping it discards the eop.
   assign eop_set  = rx_eop && rd_valid && !(pop_eff && (count == (AW+1)'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag <= '0;
      end else begin
         if (wr_en) begin
            tag[wr_ptr] <= 1'b0;
         end
         if (eop_set) begin
            tag[last_ptr] <= 1'b1;
         end
      end
   end

   assign rd_eop = rd_valid && tag[rd_ptr];
`else
   logic unused_eop;
   assign unused_eop = rx_eop;
   assign rd_eop     = 1'b0;
`endif

endmodule
